// File: rtl/mux_arb16.sv
// ---------------------------------------------------------------------------
// mux_arb16
// Round-robin arbiter that shares a 16:1 gate multiplexer among 16
// requesters. It drives the registered 4-bit mux select and a one-hot grant
// back to the winning requester. An owner keeps the grant while it keeps
// requesting, but only for up to MAX_HOLD consecutive cycles, after which the
// next requester in round-robin order takes over.
//
// Parameters
//   MAX_HOLD : maximum consecutive cycles a single grant may last (1..15)
//   CNT_W    : hold counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   CLK   : clock, all state changes on the rising edge
//   RESET : synchronous active-high reset
//   REQ   : request vector, bit i is requester i (mux data input i)
//   SEL   : registered mux select, binary index of the current owner
//   GNT   : registered one-hot grant, all zero when nobody owns the mux
//   VALID : registered, high whenever GNT is non-zero
// ---------------------------------------------------------------------------
module mux_arb16 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] REQ,
   output logic [3:0]  SEL,
   output logic [15:0] GNT,
   output logic        VALID
);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t            r_state;
   logic [3:0]        r_sel;
   logic [15:0]       r_gnt;
   logic              r_valid;
   logic [CNT_W-1:0]  r_cnt;

   state_t            w_nextState;
   logic [3:0]        w_nextSel;
   logic [15:0]       w_nextGnt;
   logic              w_nextValid;
   logic [CNT_W-1:0]  w_nextCnt;

   logic [3:0]        w_win;
   logic [3:0]        w_idx;
   logic              w_found;
   logic              w_anyReq;
   logic              w_release;

   // Round-robin search. The scan starts one past the current select and
   // wraps around; the sixteenth step lands back on the current select, so
   // the present owner is only picked when nobody else is asking. Because
   // SEL resets to 15, requester 0 is first in line after reset.
   always_comb begin
      w_win   = r_sel;
      w_found = 1'b0;
      w_idx   = r_sel;
      for (int k = 1; k <= 16; k++) begin
         w_idx = r_sel + 4'(k);
         if (!w_found && REQ[w_idx]) begin
            w_win   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   // A release is due when the owner drops its request or has used up its
   // full hold allowance. Outside OWN the value is simply not consulted.
   always_comb begin
      w_anyReq  = |REQ;
      w_release = !REQ[r_sel] || (r_cnt == CNT_W'(MAX_HOLD));
   end

   // Next-state and next-output logic. When a release is due and requests
   // remain, the next winner is granted at the same edge so the mux never
   // sees a dead cycle between owners. A lone owner that times out falls out
   // of the same search as the only candidate and is re-granted. Going idle
   // leaves SEL on the old owner so the next search starts just past it.
   always_comb begin
      w_nextState = r_state;
      w_nextSel   = r_sel;
      w_nextGnt   = r_gnt;
      w_nextValid = r_valid;
      w_nextCnt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
               w_nextState = OWN;
               w_nextSel   = w_win;
               w_nextGnt   = 16'h0001 << w_win;
               w_nextValid = 1'b1;
               w_nextCnt   = CNT_W'(1);
            end else begin
               w_nextGnt   = 16'h0000;
               w_nextValid = 1'b0;
            end
         end
         OWN: begin
            if (!w_release) begin
               w_nextCnt = r_cnt + CNT_W'(1);
            end else if (w_anyReq) begin
               w_nextSel   = w_win;
               w_nextGnt   = 16'h0001 << w_win;
               w_nextValid = 1'b1;
               w_nextCnt   = CNT_W'(1);
            end else begin
               w_nextState = IDLE;
               w_nextGnt   = 16'h0000;
               w_nextValid = 1'b0;
               w_nextCnt   = '0;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextGnt   = 16'h0000;
            w_nextValid = 1'b0;
            w_nextCnt   = '0;
         end
      endcase
   end

   // State and output registers. Reset wins over any request activity and
   // parks SEL at 15 so that requester 0 has top priority afterwards.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= IDLE;
         r_sel   <= 4'b1111;
         r_gnt   <= 16'h0000;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_sel   <= w_nextSel;
         r_gnt   <= w_nextGnt;
         r_valid <= w_nextValid;
         r_cnt   <= w_nextCnt;
      end
   end

   assign SEL   = r_sel;
   assign GNT   = r_gnt;
   assign VALID = r_valid;

endmodule

// File: doc/mux_arb16.md
Name: mux_arb16

Overview:
- Round-robin arbiter that lets 16 requesters share the 16:1 gate multiplexer.
- It drives the mux's 4-bit select and issues a one-hot grant back to the winning requester.
- A grant is held while the requester keeps its request, capped at MAX_HOLD cycles, so no source can starve the others.
- Sits between the 16 source blocks and the select input of the 16:1 mux.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may last. Legal range 1..15.
- CNT_W, 4, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  16  request vector; bit i is requester i, which maps to mux data input i (bit 0 = A ... bit 15 = P).
- SEL  output  4  registered mux select; the binary index of the current owner.
- GNT  output  16  registered one-hot grant; all zero when no owner.
- VALID  output  1  registered; high when GNT is non-zero, so SEL addresses a granted source.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - state IDLE, GNT=16'h0000, VALID=0, SEL=4'b1111, hold counter=0.
  - SEL=15 at reset makes requester 0 highest priority on the first arbitration.
- States: IDLE, OWN.
- Search order is used by every arbitration:
  - Start at index SEL+1 (mod 16) and scan upward with wrap-around.
  - The first index with REQ set wins.
  - The current SEL index is scanned last, i.e. it has lowest priority.
- IDLE:
  - If REQ==0: stay in IDLE; SEL holds its value; GNT=0; VALID=0.
  - Else: at the next edge the winner w is registered: SEL=w, GNT=1<<w, VALID=1, counter=1, go to OWN.
  - Latency from REQ seen to GNT asserted is exactly one clock.
- OWN, owner o=SEL. A release is due at the edge when REQ[o]==0 or counter==MAX_HOLD.
  - No release due: hold SEL/GNT/VALID; counter increments.
  - Release due, another REQ bit set: at the same edge grant the next winner by the search order; counter=1; stay in OWN. There is no dead cycle between owners.
  - Release due, no other request, REQ[o]==1 (timeout): re-grant o; counter=1; stay in OWN.
  - Release due, REQ==0: go to IDLE; GNT=0; VALID=0; SEL keeps o, so the next search starts at o+1.
- REQ bits that rise or fall while another requester owns the grant have no effect until the next release edge.
- Invariants:
  - GNT is always zero or one-hot.
  - When VALID=1, GNT==(1<<SEL).
  - Counter never exceeds MAX_HOLD.
- RESET asserted mid-grant overrides everything: outputs return to reset values at that edge, regardless of REQ.
- MAX_HOLD=1: every owner is released after one cycle, giving pure one-cycle round-robin rotation among active requesters.
- Arithmetic: SEL+1 wraps 15 -> 0. The counter is CNT_W bits unsigned.
- SEL never changes while VALID=1 unless a release edge occurs, so the combinational mux output is stable during a grant.

Test Plan:
- Reset then idle:
  - RESET=1 for 2 cycles, REQ=0.
  - Required: SEL=15, GNT=0, VALID=0, held for 5 further cycles with RESET=0.
- Single requester, short hold:
  - Raise REQ=16'h0010 for 3 cycles, then drop it.
  - Required: one cycle after the raise, SEL=4, GNT=16'h0010, VALID=1 for 3 cycles.
  - Then VALID=0, GNT=0, SEL stays 4.
- Round-robin rotation:
  - REQ=16'h8001 held constant, MAX_HOLD=8, starting from reset.
  - Required: requester 0 granted 8 cycles, then 15 for 8, then 0 for 8.
  - No cycle has VALID=0 after the first grant.
- Wrap-around and priority:
  - After requester 14 releases, assert REQ=16'h0005.
  - Required: SEL=0 granted first, since the search runs 15, 0, 1, 2.
  - Then SEL=2 after 0 releases.
- Timeout self re-grant:
  - REQ=16'h0200 held for 20 cycles.
  - Required: SEL=9 throughout, VALID=1 throughout, and the counter restarts at 1 on cycles 9 and 17 after the grant.
- Reset mid-operation:
  - RESET=1 while SEL=6 and VALID=1, with REQ=16'h0040 still held.
  - Required: at that edge SEL=15, GNT=0, VALID=0.
  - One cycle after RESET falls, SEL=6 is re-granted with counter=1.
